// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, result-broadcast and issue signals of the ALU reservation station.
// slave is the reservation station's view; master is the surrounding core's view.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

interface alu_rs_if;
    // dispatch
    logic                       dp_valid;
    logic [`ALU_OP_WIDTH-1:0]   dp_op;
    logic                       dp_has_q1;
    logic [`ROB_SIZE_WIDTH-1:0] dp_q1;
    logic [`XLEN-1:0]           dp_val1;
    logic                       dp_has_q2;
    logic [`ROB_SIZE_WIDTH-1:0] dp_q2;
    logic [`XLEN-1:0]           dp_val2;
    logic [`ROB_SIZE_WIDTH-1:0] dp_id;
    logic                       rs_full;
    // result broadcasts
    logic                       alu_ready;
    logic [`ROB_SIZE_WIDTH-1:0] alu_id;
    logic [`XLEN-1:0]           alu_res;
    logic                       lsb_ready;
    logic [`ROB_SIZE_WIDTH-1:0] lsb_id;
    logic [`XLEN-1:0]           lsb_res;
    // issue to ALU
    logic                       rs_ready;
    logic [`ALU_OP_WIDTH-1:0]   rs_op;
    logic [`XLEN-1:0]           rs_val1;
    logic [`XLEN-1:0]           rs_val2;
    logic [`ROB_SIZE_WIDTH-1:0] rs_id;

    modport master (
        output dp_valid, dp_op, dp_has_q1, dp_q1, dp_val1,
               dp_has_q2, dp_q2, dp_val2, dp_id,
               alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res,
        input  rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );

    modport slave (
        input  dp_valid, dp_op, dp_has_q1, dp_q1, dp_val1,
               dp_has_q2, dp_q2, dp_val2, dp_id,
               alu_ready, alu_id, alu_res, lsb_ready, lsb_id, lsb_res,
        output rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
    );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station for the integer ALU (2**RS_SIZE_WIDTH entries).
// Holds dispatched ops until both operands are known, snoops ALU/LSB result
// broadcasts and issues the lowest-index ready entry each cycle.
// Optional macro ALU_RS_BYPASS_EN: a fully ready dispatch issues on its own
// dispatch edge when no buffered entry is issuable.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module alu_rs #(
    parameter int unsigned RS_SIZE_WIDTH = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rdy,
    input  logic    flush,
    alu_rs_if.slave bus
);
    localparam int unsigned RS_SIZE = 1 << RS_SIZE_WIDTH;
    localparam int unsigned OPW     = `ALU_OP_WIDTH;
    localparam int unsigned TW      = `ROB_SIZE_WIDTH;
    localparam int unsigned XW      = `XLEN;

    typedef logic [RS_SIZE_WIDTH-1:0] idx_t;

    // entry storage
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] has1_q, has1_d;
    logic [RS_SIZE-1:0] has2_q, has2_d;
    logic [OPW-1:0]     op_q   [RS_SIZE];
    logic [OPW-1:0]     op_d   [RS_SIZE];
    logic [TW-1:0]      q1_q   [RS_SIZE];
    logic [TW-1:0]      q1_d   [RS_SIZE];
    logic [TW-1:0]      q2_q   [RS_SIZE];
    logic [TW-1:0]      q2_d   [RS_SIZE];
    logic [TW-1:0]      id_q   [RS_SIZE];
    logic [TW-1:0]      id_d   [RS_SIZE];
    logic [XW-1:0]      val1_q [RS_SIZE];
    logic [XW-1:0]      val1_d [RS_SIZE];
    logic [XW-1:0]      val2_q [RS_SIZE];
    logic [XW-1:0]      val2_d [RS_SIZE];

    // issue registers
    logic               rs_ready_q, rs_ready_d;
    logic [OPW-1:0]     rs_op_q,    rs_op_d;
    logic [XW-1:0]      rs_val1_q,  rs_val1_d;
    logic [XW-1:0]      rs_val2_q,  rs_val2_d;
    logic [TW-1:0]      rs_id_q,    rs_id_d;

    logic               issue_found;
    idx_t               issue_idx;
    logic               free_found;
    idx_t               free_idx;
    logic               full;
    logic               dp_has1, dp_has2;
    logic [XW-1:0]      dp_v1, dp_v2;

    assign full         = &busy_q;
    assign bus.rs_full  = full;
    assign bus.rs_ready = rs_ready_q;
    assign bus.rs_op    = rs_op_q;
    assign bus.rs_val1  = rs_val1_q;
    assign bus.rs_val2  = rs_val2_q;
    assign bus.rs_id    = rs_id_q;

    // Lowest-index issuable and lowest-index free entry, both from pre-edge state.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!issue_found && busy_q[i] && !has1_q[i] && !has2_q[i]) begin
                issue_found = 1'b1;
                issue_idx   = idx_t'(i);
            end
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
        end
    end

    // Resolve dispatched operands against this cycle's broadcasts (ALU wins a tie).
    always_comb begin
        dp_has1 = bus.dp_has_q1;
        dp_v1   = bus.dp_val1;
        dp_has2 = bus.dp_has_q2;
        dp_v2   = bus.dp_val2;
        if (bus.dp_has_q1) begin
            if (bus.alu_ready && bus.alu_id == bus.dp_q1) begin
                dp_has1 = 1'b0;
                dp_v1   = bus.alu_res;
            end else if (bus.lsb_ready && bus.lsb_id == bus.dp_q1) begin
                dp_has1 = 1'b0;
                dp_v1   = bus.lsb_res;
            end
        end
        if (bus.dp_has_q2) begin
            if (bus.alu_ready && bus.alu_id == bus.dp_q2) begin
                dp_has2 = 1'b0;
                dp_v2   = bus.alu_res;
            end else if (bus.lsb_ready && bus.lsb_id == bus.dp_q2) begin
                dp_has2 = 1'b0;
                dp_v2   = bus.lsb_res;
            end
        end
    end

    // Next state: wake-up, issue, dispatch, then flush overriding all of it.
    always_comb begin
        busy_d    = busy_q;
        has1_d    = has1_q;
        has2_d    = has2_q;
        op_d      = op_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        id_d      = id_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        rs_ready_d = 1'b0;
        rs_op_d    = rs_op_q;
        rs_val1_d  = rs_val1_q;
        rs_val2_d  = rs_val2_q;
        rs_id_d    = rs_id_q;

        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && has1_q[i]) begin
                if (bus.alu_ready && bus.alu_id == q1_q[i]) begin
                    has1_d[i] = 1'b0;
                    val1_d[i] = bus.alu_res;
                end else if (bus.lsb_ready && bus.lsb_id == q1_q[i]) begin
                    has1_d[i] = 1'b0;
                    val1_d[i] = bus.lsb_res;
                end
            end
            if (busy_q[i] && has2_q[i]) begin
                if (bus.alu_ready && bus.alu_id == q2_q[i]) begin
                    has2_d[i] = 1'b0;
                    val2_d[i] = bus.alu_res;
                end else if (bus.lsb_ready && bus.lsb_id == q2_q[i]) begin
                    has2_d[i] = 1'b0;
                    val2_d[i] = bus.lsb_res;
                end
            end
        end

        if (issue_found) begin
            busy_d[issue_idx] = 1'b0;
            rs_ready_d        = 1'b1;
            rs_op_d           = op_q[issue_idx];
            rs_val1_d         = val1_q[issue_idx];
            rs_val2_d         = val2_q[issue_idx];
            rs_id_d           = id_q[issue_idx];
        end

        // free_idx comes from pre-edge busy, so a slot vacated by this edge's
        // issue is never picked here.
        if (bus.dp_valid && !full) begin
`ifdef ALU_RS_BYPASS_EN
            if (!issue_found && !dp_has1 && !dp_has2) begin
                rs_ready_d = 1'b1;
                rs_op_d    = bus.dp_op;
                rs_val1_d  = dp_v1;
                rs_val2_d  = dp_v2;
                rs_id_d    = bus.dp_id;
            end else
`endif
            begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = bus.dp_op;
                has1_d[free_idx] = dp_has1;
                q1_d[free_idx]   = bus.dp_q1;
                val1_d[free_idx] = dp_v1;
                has2_d[free_idx] = dp_has2;
                q2_d[free_idx]   = bus.dp_q2;
                val2_d[free_idx] = dp_v2;
                id_d[free_idx]   = bus.dp_id;
            end
        end

        if (flush) begin
            busy_d     = '0;
            rs_ready_d = 1'b0;
        end
    end

    // State update; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            has1_q     <= '0;
            has2_q     <= '0;
            op_q       <= '{default: '0};
            q1_q       <= '{default: '0};
            q2_q       <= '{default: '0};
            id_q       <= '{default: '0};
            val1_q     <= '{default: '0};
            val2_q     <= '{default: '0};
            rs_ready_q <= 1'b0;
            rs_op_q    <= '0;
            rs_val1_q  <= '0;
            rs_val2_q  <= '0;
            rs_id_q    <= '0;
        end else if (rdy) begin
            busy_q     <= busy_d;
            has1_q     <= has1_d;
            has2_q     <= has2_d;
            op_q       <= op_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            id_q       <= id_d;
            val1_q     <= val1_d;
            val2_q     <= val2_d;
            rs_ready_q <= rs_ready_d;
            rs_op_q    <= rs_op_d;
            rs_val1_q  <= rs_val1_d;
            rs_val2_q  <= rs_val2_d;
            rs_id_q    <= rs_id_d;
        end
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU in the Tomasulo core.
- Accepts dispatched ALU ops, holding either operand values or ROB tags for each operand.
- Snoops the ALU and LSB result broadcasts to wake waiting operands.
- Issues one ready op per cycle on the rs_* interface that the ALU consumes.

Parameters:
- RS_SIZE_WIDTH, 3, log2 of entry count (RS_SIZE = 2**RS_SIZE_WIDTH = 8 entries).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction flush
- dp_valid  in  1  dispatch request this cycle
- dp_op  in  `ALU_OP_WIDTH  ALU opcode
- dp_has_q1  in  1  operand 1 waits on ROB tag dp_q1
- dp_q1  in  `ROB_SIZE_WIDTH  producer tag, operand 1
- dp_val1  in  `XLEN  operand 1 value when !dp_has_q1
- dp_has_q2  in  1  operand 2 waits on tag dp_q2
- dp_q2  in  `ROB_SIZE_WIDTH  producer tag, operand 2
- dp_val2  in  `XLEN  operand 2 value when !dp_has_q2
- dp_id  in  `ROB_SIZE_WIDTH  destination ROB id
- rs_full  out  1  all entries valid
- alu_ready  in  1  ALU broadcast valid
- alu_id  in  `ROB_SIZE_WIDTH  ALU broadcast tag
- alu_res  in  `XLEN  ALU broadcast value
- lsb_ready  in  1  LSB broadcast valid
- lsb_id  in  `ROB_SIZE_WIDTH  LSB broadcast tag
- lsb_res  in  `XLEN  LSB broadcast value
- rs_ready  out  1  issue valid to ALU (registered)
- rs_op  out  `ALU_OP_WIDTH  issued opcode
- rs_val1  out  `XLEN  issued operand 1
- rs_val2  out  `XLEN  issued operand 2
- rs_id  out  `ROB_SIZE_WIDTH  issued ROB id

Behaviour:
- Entry state: busy, op, has_q1/q1/val1, has_q2/q2/val2, id.
- An entry is issuable when busy && !has_q1 && !has_q2, evaluated on pre-edge state.
- Reset (rst low, asynchronous): all busy=0; rs_ready=0, rs_op=0, rs_val1=0, rs_val2=0, rs_id=0.
- rdy low: no dispatch, wake-up, issue or flush takes effect; all outputs hold.
- flush (rdy high): all busy=0 and rs_ready<=0 at that edge; a dp_valid on the same edge is dropped. Flush has priority over everything else.
- Issue: at each edge, the lowest-index issuable entry is copied to rs_* with rs_ready<=1 and its busy cleared. With no issuable entry, rs_ready<=0 and rs_op/val/id hold.
- Dispatch:
  - dp_valid && !rs_full: the write goes into the lowest-index free entry.
  - An entry freed by issue on the same edge is not reused until the next cycle.
  - dp_valid while rs_full is a protocol violation and is ignored.
- Dispatch snoop: if dp_has_qN and (alu_ready && alu_id==dp_qN) or (lsb_ready && lsb_id==dp_qN), the entry stores the value with has_qN=0. ALU takes precedence if both match.
- Wake-up: every busy entry with has_qN and a matching broadcast captures the value and clears has_qN at that edge. Both operands may wake on the same edge.
  - A woken entry is issuable from the next cycle; single-cycle wait minimum.
- Latency: a ready-at-dispatch op in an otherwise empty RS reaches rs_ready one cycle after the dispatch edge.
- rs_full: combinational, 1 iff all RS_SIZE entries are busy.
- Ordering: issue is index-priority, not age-priority. The ROB restores program order.

Optional Feature:
- Macro: ALU_RS_BYPASS_EN.
- When defined: a dispatch whose operands are both ready, including via dispatch snoop, drives rs_* directly on the dispatch edge without occupying an entry. This applies only when no buffered entry is issuable that edge, and it lowers latency to 0 extra cycles.
- When undefined: every dispatch goes through an entry, and latency is exactly as above.

Test Plan:
- Reset: drive rst=0 mid-run with 3 busy entries -> rs_ready=0 immediately; after release, rs_full=0 and no issue occurs.
- Simple issue: dispatch op=ADD, val1=5, val2=7, id=3 into an empty RS -> next edge rs_ready=1, rs_val1=5, rs_val2=7, rs_id=3; the following edge rs_ready=0. With ALU_RS_BYPASS_EN, rs_ready=1 on the dispatch edge.
- Wake-up: dispatch with has_q1, q1=9, val2=2, id=4; two cycles later pulse alu_ready, alu_id=9, alu_res=0x10 -> issue on the edge after with rs_val1=0x10 and rs_id=4.
- Dispatch snoop: dispatch has_q2, q2=6 while lsb_ready=1, lsb_id=6, lsb_res=0xAB on the same cycle -> next edge rs_val2=0xAB issues.
- Full: 8 dependent dispatches -> rs_full=1; a 9th dispatch is ignored; a broadcast frees one entry after issue -> rs_full=0.
- Flush and rdy: with 5 busy entries, set flush=1 with rdy=1 -> all entries cleared and rs_ready=0. Then rdy=0 with a pending ready entry -> no issue until rdy returns.
